// File: rtl/bp_be_fp_nanbox_pipe_if.sv
// Request/response bundle for the NaN-boxing pipe.
// The master drives beats in and consumes results; the slave is the pipe itself.
interface bp_be_fp_nanbox_pipe_if #(
  parameter int lanes_p = 1
);
  logic                   v_i;
  logic                   ready_and_o;
  logic [1:0]             op_i;
  logic [1:0]             fmt_i;
  logic [64*lanes_p-1:0]  data_i;
  logic                   v_o;
  logic                   ready_and_i;
  logic [64*lanes_p-1:0]  data_o;
  logic [lanes_p-1:0]     bad_box_o;

  modport master (
    output v_i, op_i, fmt_i, data_i, ready_and_i,
    input  ready_and_o, v_o, data_o, bad_box_o
  );

  modport slave (
    input  v_i, op_i, fmt_i, data_i, ready_and_i,
    output ready_and_o, v_o, data_o, bad_box_o
  );
endinterface

// File: rtl/bp_be_fp_nanbox_pipe.sv
// Multi-lane box/unbox/classify of IEEE dp/sp/hp values; result computed in stage 0, latency stages_p.
// One global stall enable (~v_o | ready_and_i) freezes every stage and doubles as ready_and_o.
module bp_be_fp_nanbox_pipe #(
  parameter int lanes_p      = 1,
  parameter int stages_p     = 2,
  parameter bit hp_support_p = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_be_fp_nanbox_pipe_if.slave  io
);

  typedef struct packed {
    logic                  v;
    logic [lanes_p-1:0]    bad;
    logic [64*lanes_p-1:0] data;
  } stage_t;

  // Returns {bad_box, data} for one 64-bit lane.
  function automatic logic [64:0] lane_f(input logic [1:0] op, input logic [1:0] fmt,
                                         input logic [63:0] d);
    logic [63:0] boxed;
    logic [63:0] unboxed;
    logic        ok;
    logic        legal;
    logic        sign;
    logic        e_ones;
    logic        e_zero;
    logic        f_zero;
    logic        f_msb;
    logic [9:0]  mask;
    logic [64:0] res;

    legal   = (op != 2'b11) && (fmt != 2'b11) && !((fmt == 2'b10) && !hp_support_p);
    boxed   = d;
    unboxed = d;
    ok      = 1'b1;
    sign    = d[63];
    e_ones  = &d[62:52];
    e_zero  = ~|d[62:52];
    f_zero  = ~|d[51:0];
    f_msb   = d[51];

    case (fmt)
      2'b01: begin
        boxed   = {32'hffff_ffff, d[31:0]};
        ok      = &d[63:32];
        unboxed = ok ? {{32{d[31]}}, d[31:0]} : 64'h0000_0000_7fc0_0000;
        sign    = unboxed[31];
        e_ones  = &unboxed[30:23];
        e_zero  = ~|unboxed[30:23];
        f_zero  = ~|unboxed[22:0];
        f_msb   = unboxed[22];
      end
      2'b10: begin
        boxed   = {48'hffff_ffff_ffff, d[15:0]};
        ok      = &d[63:16];
        unboxed = ok ? {{48{d[15]}}, d[15:0]} : 64'h0000_0000_0000_7e00;
        sign    = unboxed[15];
        e_ones  = &unboxed[14:10];
        e_zero  = ~|unboxed[14:10];
        f_zero  = ~|unboxed[9:0];
        f_msb   = unboxed[9];
      end
      default: ;
    endcase

    if (e_ones && f_zero)      mask = sign ? 10'h001 : 10'h080;
    else if (e_ones)           mask = f_msb ? 10'h200 : 10'h100;
    else if (e_zero && f_zero) mask = sign ? 10'h008 : 10'h010;
    else if (e_zero)           mask = sign ? 10'h004 : 10'h020;
    else                       mask = sign ? 10'h002 : 10'h040;

    if (!legal) begin
      res = {1'b1, 64'h0};
    end else begin
      case (op)
        2'b00:   res = {1'b0, boxed};
        2'b01:   res = {~ok, unboxed};
        default: res = {~ok, 54'h0, mask};
      endcase
    end
    return res;
  endfunction

  stage_t [stages_p-1:0] stg_q;
  stage_t [stages_p-1:0] stg_d;
  stage_t                in_s;
  logic   [64:0]         lane_res;
  logic                  en;

  assign en             = ~stg_q[stages_p-1].v | io.ready_and_i;
  assign io.ready_and_o = en;
  assign io.v_o         = stg_q[stages_p-1].v;
  assign io.data_o      = stg_q[stages_p-1].data;
  assign io.bad_box_o   = stg_q[stages_p-1].bad;

  // Bubbles carry zero data so an idle output never shows stale results.
  always_comb begin
    in_s     = '0;
    lane_res = '0;
    in_s.v   = io.v_i;
    if (io.v_i) begin
      for (int i = 0; i < lanes_p; i++) begin
        lane_res              = lane_f(io.op_i, io.fmt_i, io.data_i[64*i +: 64]);
        in_s.bad[i]           = lane_res[64];
        in_s.data[64*i +: 64] = lane_res[63:0];
      end
    end
  end

  always_comb begin
    stg_d = stg_q;
    if (en) begin
      stg_d[0] = in_s;
      for (int k = 1; k < stages_p; k++) begin
        stg_d[k] = stg_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

endmodule

// File: tb/tb_bp_be_fp_nanbox_pipe.sv
// Directed scoreboard bench for bp_be_fp_nanbox_pipe with two lanes and two stages.
module tb_bp_be_fp_nanbox_pipe;
  localparam int L = 2;
  localparam int S = 2;

  typedef struct {
    logic [64*L-1:0] d;
    logic [L-1:0]    b;
    int              t;
    bit              lat;
    string           tag;
  } exp_t;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  bp_be_fp_nanbox_pipe_if #(.lanes_p(L)) io ();

  bp_be_fp_nanbox_pipe #(.lanes_p(L), .stages_p(S), .hp_support_p(1'b1)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .io     (io)
  );

  always #5 clk_i = ~clk_i;

  exp_t            q[$];
  exp_t            nx;
  int              total = 0;
  int              bad   = 0;
  int              cyc_n = 0;
  int              sent;
  bit              stall_prev = 1'b0;
  bit              bp_mode    = 1'b0;
  bit              acc;
  logic [64*L-1:0] hold_d;
  logic [L-1:0]    hold_b;
  logic [127:0]    rd;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check stall hold, retire against the scoreboard, record an accept.
  task automatic step(output bit accepted);
    exp_t e;
    #1;
    if (!reset_i) begin
      if (stall_prev) begin
        chk("stall_hold_v", 128'(io.v_o), 128'(1));
        chk("stall_hold_data", 128'(io.data_o), 128'(hold_d));
        chk("stall_hold_bad", 128'(io.bad_box_o), 128'(hold_b));
      end
      if (bp_mode) chk("ready_rule", 128'(io.ready_and_o), 128'(!(io.v_o && !io.ready_and_i)));
      if (io.v_o && io.ready_and_i) begin
        if (q.size() == 0) begin
          chk("spurious_out", 128'(io.v_o), 128'(0));
        end else begin
          e = q.pop_front();
          chk({e.tag, "_data"}, 128'(io.data_o), 128'(e.d));
          chk({e.tag, "_bad"}, 128'(io.bad_box_o), 128'(e.b));
          if (e.lat) chk({e.tag, "_lat"}, 128'(cyc_n - e.t), 128'(S));
        end
      end
    end
    stall_prev = io.v_o && !io.ready_and_i && !reset_i;
    hold_d     = io.data_o;
    hold_b     = io.bad_box_o;
    accepted   = io.v_i && io.ready_and_o && !reset_i;
    if (accepted) begin
      nx.t = cyc_n;
      q.push_back(nx);
    end
    @(posedge clk_i);
    cyc_n++;
    @(negedge clk_i);
  endtask

  task automatic beat(input logic [1:0] op, input logic [1:0] fmt, input logic [127:0] d,
                      input logic [127:0] ed, input logic [1:0] eb, input bit lat, input string tag);
    bit a;
    io.v_i    = 1'b1;
    io.op_i   = op;
    io.fmt_i  = fmt;
    io.data_i = d;
    nx.d      = ed;
    nx.b      = eb;
    nx.lat    = lat;
    nx.tag    = tag;
    nx.t      = 0;
    step(a);
    chk({tag, "_acc"}, 128'(a), 128'(1));
  endtask

  task automatic idle();
    bit a;
    io.v_i = 1'b0;
    step(a);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle();
    chk("drain_empty", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    io.v_i         = 1'b0;
    io.op_i        = 2'b00;
    io.fmt_i       = 2'b00;
    io.data_i      = '0;
    io.ready_and_i = 1'b1;
    @(negedge clk_i);

    // Reset, with a beat presented that must be ignored.
    reset_i = 1'b1;
    io.v_i  = 1'b1;
    step(acc);
    step(acc);
    reset_i        = 1'b0;
    io.v_i         = 1'b0;
    io.ready_and_i = 1'b0;
    #1;
    chk("rst_v", 128'(io.v_o), 128'(0));
    chk("rst_data", 128'(io.data_o), 128'(0));
    chk("rst_bad", 128'(io.bad_box_o), 128'(0));
    chk("rst_ready", 128'(io.ready_and_o), 128'(1));
    io.ready_and_i = 1'b1;
    @(negedge clk_i);

    beat(2'b00, 2'b01, {64'h1234_5678_4000_0000, 64'h0000_0000_3f80_0000},
         {64'hffff_ffff_4000_0000, 64'hffff_ffff_3f80_0000}, 2'b00, 1'b1, "box_sp");
    drain();

    beat(2'b01, 2'b01, {64'hffff_ffff_bf80_0000, 64'h0000_0000_3f80_0000},
         {64'hffff_ffff_bf80_0000, 64'h0000_0000_7fc0_0000}, 2'b01, 1'b1, "unbox_sp");
    beat(2'b10, 2'b10, {64'hffff_ffff_ffff_7d00, 64'hffff_ffff_ffff_7c00},
         {64'h100, 64'h080}, 2'b00, 1'b1, "cls_hp_inf_snan");
    beat(2'b10, 2'b10, {64'h0000_0000_0000_3c00, 64'hffff_ffff_ffff_8001},
         {64'h200, 64'h004}, 2'b10, 1'b1, "cls_hp_qnan_sub");
    beat(2'b10, 2'b00, {64'h7ff0_0000_0000_0000, 64'h8000_0000_0000_0000},
         {64'h080, 64'h008}, 2'b00, 1'b1, "cls_dp");
    beat(2'b10, 2'b01, {64'hffff_ffff_0000_0000, 64'hffff_ffff_7f80_0001},
         {64'h010, 64'h100}, 2'b00, 1'b1, "cls_sp");
    beat(2'b00, 2'b10, {64'h1111_2222_3333_4444, 64'h0000_0000_0000_abcd},
         {64'hffff_ffff_ffff_4444, 64'hffff_ffff_ffff_abcd}, 2'b00, 1'b1, "box_hp");
    beat(2'b01, 2'b10, {64'hffff_ffff_ffff_0123, 64'hffff_ffff_ffff_8123},
         {64'h0000_0000_0000_0123, 64'hffff_ffff_ffff_8123}, 2'b00, 1'b1, "unbox_hp");
    beat(2'b01, 2'b00, {64'hfedc_ba98_7654_3210, 64'h0123_4567_89ab_cdef},
         {64'hfedc_ba98_7654_3210, 64'h0123_4567_89ab_cdef}, 2'b00, 1'b1, "unbox_dp");
    beat(2'b11, 2'b01, {64'hffff_ffff_3f80_0000, 64'h1}, 128'h0, 2'b11, 1'b1, "illegal_op");
    beat(2'b00, 2'b11, {64'h5, 64'h6}, 128'h0, 2'b11, 1'b1, "illegal_fmt");
    drain();

    // Backpressure stream: consumer ready pattern 1,0,0,1.
    bp_mode = 1'b1;
    sent    = 0;
    rd      = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 80 && sent < 8; c++) begin
      io.ready_and_i = (c % 4 == 0) || (c % 4 == 3);
      io.v_i         = 1'b1;
      io.op_i        = 2'b00;
      io.fmt_i       = 2'b01;
      io.data_i      = rd;
      nx.d           = {32'hffff_ffff, rd[95:64], 32'hffff_ffff, rd[31:0]};
      nx.b           = 2'b00;
      nx.lat         = 1'b0;
      nx.tag         = "bp";
      step(acc);
      if (acc) begin
        sent++;
        rd = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    io.v_i = 1'b0;
    chk("bp_sent", 128'(sent), 128'(8));
    for (int c = 0; c < 12 && q.size() > 0; c++) begin
      io.ready_and_i = (c % 4 == 0) || (c % 4 == 3);
      step(acc);
    end
    io.ready_and_i = 1'b1;
    drain();
    bp_mode = 1'b0;

    // Reset with two beats in flight.
    beat(2'b00, 2'b10, {64'h0, 64'h1}, {64'hffff_ffff_ffff_0000, 64'hffff_ffff_ffff_0001},
         2'b00, 1'b0, "pre_rst_a");
    beat(2'b00, 2'b10, {64'h2, 64'h3}, {64'hffff_ffff_ffff_0002, 64'hffff_ffff_ffff_0003},
         2'b00, 1'b0, "pre_rst_b");
    reset_i = 1'b1;
    io.v_i  = 1'b1;
    step(acc);
    reset_i        = 1'b0;
    io.v_i         = 1'b0;
    stall_prev     = 1'b0;
    q.delete();
    io.ready_and_i = 1'b0;
    #1;
    chk("rst2_v", 128'(io.v_o), 128'(0));
    chk("rst2_data", 128'(io.data_o), 128'(0));
    chk("rst2_bad", 128'(io.bad_box_o), 128'(0));
    chk("rst2_ready", 128'(io.ready_and_o), 128'(1));
    io.ready_and_i = 1'b1;
    @(negedge clk_i);
    beat(2'b00, 2'b01, {64'h0, 64'hdead_beef}, {64'hffff_ffff_0000_0000, 64'hffff_ffff_dead_beef},
         2'b00, 1'b1, "post_rst");
    for (int i = 0; i < 5; i++) idle();
    chk("post_rst_empty", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
